// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response handshake bundle for both ALU requesters
interface alu_share_arbiter_if #(
    parameter int TAG_W = 3
);
    logic              req0Valid;
    logic              req0Ready;
    logic [3:0]        req0Op;
    logic [31:0]       req0A;
    logic [31:0]       req0B;
    logic [TAG_W-1:0]  req0Tag;
    logic              rsp0Valid;
    logic              rsp0Ready;
    logic [31:0]       rsp0Data;
    logic              rsp0Exc;
    logic [TAG_W-1:0]  rsp0Tag;

    logic              req1Valid;
    logic              req1Ready;
    logic [3:0]        req1Op;
    logic [31:0]       req1A;
    logic [31:0]       req1B;
    logic [TAG_W-1:0]  req1Tag;
    logic              rsp1Valid;
    logic              rsp1Ready;
    logic [31:0]       rsp1Data;
    logic              rsp1Exc;
    logic [TAG_W-1:0]  rsp1Tag;

    modport slave (
        input  req0Valid, req0Op, req0A, req0B, req0Tag, rsp0Ready,
        input  req1Valid, req1Op, req1A, req1B, req1Tag, rsp1Ready,
        output req0Ready, rsp0Valid, rsp0Data, rsp0Exc, rsp0Tag,
        output req1Ready, rsp1Valid, rsp1Data, rsp1Exc, rsp1Tag
    );

    modport master (
        output req0Valid, req0Op, req0A, req0B, req0Tag, rsp0Ready,
        output req1Valid, req1Op, req1A, req1B, req1Tag, rsp1Ready,
        input  req0Ready, rsp0Valid, rsp0Data, rsp0Exc, rsp0Tag,
        input  req1Ready, rsp1Valid, rsp1Data, rsp1Exc, rsp1Tag
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters with one-entry response slots
module alu_share_arbiter #(
    parameter int TAG_W      = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    alu_share_arbiter_if.slave  req_rsp,
    output logic [3:0]          aluOp,
    output logic [31:0]         aluDin1,
    output logic [31:0]         aluDin2,
    input  logic [31:0]         aluDout,
    input  logic                aluException,
    output logic                busy
);
    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [3:0]       req_op  [2];
    logic [31:0]      req_a   [2];
    logic [31:0]      req_b   [2];
    logic [TAG_W-1:0] req_tag [2];

    logic [1:0]       avail;
    logic [1:0]       elig;
    logic [1:0]       grant;

    logic             last_grant_q, last_grant_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q [2];
    logic [31:0]      rsp_data_d [2];
    logic [1:0]       rsp_exc_q, rsp_exc_d;
    logic [TAG_W-1:0] rsp_tag_q [2];
    logic [TAG_W-1:0] rsp_tag_d [2];

    always_comb begin
        req_valid  = {req_rsp.req1Valid, req_rsp.req0Valid};
        rsp_ready  = {req_rsp.rsp1Ready, req_rsp.rsp0Ready};
        req_op[0]  = req_rsp.req0Op;
        req_op[1]  = req_rsp.req1Op;
        req_a[0]   = req_rsp.req0A;
        req_a[1]   = req_rsp.req1A;
        req_b[0]   = req_rsp.req0B;
        req_b[1]   = req_rsp.req1B;
        req_tag[0] = req_rsp.req0Tag;
        req_tag[1] = req_rsp.req1Tag;
    end

    // A slot draining this cycle can accept a new result on the same edge.
    always_comb begin
        avail = ~rsp_valid_q | rsp_ready;
        elig  = req_valid & avail;
        grant = elig;
        if (elig == 2'b11) begin
            grant = (FIXED_PRIO || last_grant_q) ? 2'b01 : 2'b10;
        end

        last_grant_d = last_grant_q;
        if (grant[1]) begin
            last_grant_d = 1'b1;
        end else if (grant[0]) begin
            last_grant_d = 1'b0;
        end

        aluOp   = 4'b0001;
        aluDin1 = 32'h0;
        aluDin2 = 32'h0;
        if (grant[1]) begin
            aluOp   = req_op[1];
            aluDin1 = req_a[1];
            aluDin2 = req_b[1];
        end else if (grant[0]) begin
            aluOp   = req_op[0];
            aluDin1 = req_a[0];
            aluDin2 = req_b[0];
        end
    end

    // The ALU result is undefined on overflow, so it is replaced by zero.
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_exc_d   = rsp_exc_q;
        for (int n = 0; n < 2; n++) begin
            rsp_data_d[n] = rsp_data_q[n];
            rsp_tag_d[n]  = rsp_tag_q[n];
            if (grant[n]) begin
                rsp_valid_d[n] = 1'b1;
                rsp_exc_d[n]   = aluException;
                rsp_data_d[n]  = aluException ? 32'h0 : aluDout;
                rsp_tag_d[n]   = req_tag[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp_exc_q    <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                rsp_data_q[n] <= 32'h0;
                rsp_tag_q[n]  <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_exc_q    <= rsp_exc_d;
            for (int n = 0; n < 2; n++) begin
                rsp_data_q[n] <= rsp_data_d[n];
                rsp_tag_q[n]  <= rsp_tag_d[n];
            end
        end
    end

    assign req_rsp.req0Ready = grant[0];
    assign req_rsp.req1Ready = grant[1];
    assign req_rsp.rsp0Valid = rsp_valid_q[0];
    assign req_rsp.rsp1Valid = rsp_valid_q[1];
    assign req_rsp.rsp0Data  = rsp_data_q[0];
    assign req_rsp.rsp1Data  = rsp_data_q[1];
    assign req_rsp.rsp0Exc   = rsp_exc_q[0];
    assign req_rsp.rsp1Exc   = rsp_exc_q[1];
    assign req_rsp.rsp0Tag   = rsp_tag_q[0];
    assign req_rsp.rsp1Tag   = rsp_tag_q[1];
    assign busy              = |rsp_valid_q;
endmodule
